// File: rtl/mips_hazard_unit.sv
// mips_hazard_unit: stall, flush and forward-select control for the pipelined MIPS core.
// Define HAZARD_PERF_EN to add the stall_count/flush_count performance counters.
module mips_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int M_STAGES = 1,
  localparam int FW = $clog2(M_STAGES + 2)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_d,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              use_rs_d,
  input  logic              use_rt_d,
  input  logic [REG_AW-1:0] dest_d,
  input  logic              reg_write_d,
  input  logic              mem_to_reg_d,
  input  logic              branch_d,
  input  logic              pc_src_d,
  input  logic              jump_d,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_x,
  output logic [FW-1:0]     fwd_a_x,
  output logic [FW-1:0]     fwd_b_x,
  output logic [FW-1:0]     fwd_a_d,
  output logic [FW-1:0]     fwd_b_d
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_count,
  output logic [31:0]       flush_count
`endif
);
  // Producers only need write-enable (valid & reg_write), dest and load; X also keeps its sources.
  typedef struct packed {
    logic              wr;
    logic [REG_AW-1:0] dest;
    logic              ld;
  } prod_t;
  typedef struct packed {
    prod_t             p;
    logic              use_rs;
    logic              use_rt;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } cons_t;
  cons_t x;
  prod_t m [M_STAGES];
  prod_t w;
  logic stall;
  logic [1:0] hx;
  logic [1:0] hm;
  // Returns {load match, any match}.
  function automatic logic [1:0] hit(input prod_t p, input logic [REG_AW-1:0] r, input logic u);
    logic h;
    h = p.wr & (p.dest == r) & (r != '0) & u;
    return {h & p.ld, h};
  endfunction
  always_comb begin
    hm = '0;
    hx = hit(x.p, rs_d, use_rs_d) | hit(x.p, rt_d, use_rt_d);
    stall = hx[1] | (branch_d & hx[0]);
    for (int k = 0; k < M_STAGES; k++) begin
      hm = hit(m[k], rs_d, use_rs_d) | hit(m[k], rt_d, use_rt_d);
      if (hm[1] && (k < M_STAGES - 1 || branch_d)) stall = 1'b1;
    end
    stall = stall & valid_d;
  end
  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_x = stall;
  assign flush_d = valid_d & (pc_src_d | jump_d) & ~stall;
  // Walk oldest to youngest so the youngest non-load match overwrites.
  always_comb begin
    fwd_a_x = |hit(w, x.rs, x.use_rs) ? FW'(M_STAGES + 1) : '0;
    fwd_b_x = |hit(w, x.rt, x.use_rt) ? FW'(M_STAGES + 1) : '0;
    fwd_a_d = '0;
    fwd_b_d = '0;
    for (int k = M_STAGES - 1; k >= 0; k--) begin
      if (hit(m[k], x.rs, x.use_rs) == 2'b01) fwd_a_x = FW'(k + 1);
      if (hit(m[k], x.rt, x.use_rt) == 2'b01) fwd_b_x = FW'(k + 1);
      if (branch_d && hit(m[k], rs_d, use_rs_d) == 2'b01) fwd_a_d = FW'(k + 1);
      if (branch_d && hit(m[k], rt_d, use_rt_d) == 2'b01) fwd_b_d = FW'(k + 1);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      w <= '0;
      for (int k = 0; k < M_STAGES; k++) m[k] <= '0;
    end else begin
      x <= (valid_d & ~stall) ? {reg_write_d, dest_d, mem_to_reg_d, use_rs_d, use_rt_d, rs_d, rt_d} : '0;
      m[0] <= x.p;
      for (int k = 1; k < M_STAGES; k++) m[k] <= m[k-1];
      w <= m[M_STAGES-1];
    end
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      stall_count <= stall_count + 32'(stall);
      flush_count <= flush_count + 32'(flush_d);
    end
  end
`endif
endmodule

// File: tb/tb_mips_hazard_unit.sv
// tb_mips_hazard_unit: M_STAGES=1 and M_STAGES=2 units driven in parallel against an age-ordered reference model.
module tb_mips_hazard_unit;
  localparam int AW = 5;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  logic valid_d, use_rs_d, use_rt_d, reg_write_d, mem_to_reg_d, branch_d, pc_src_d, jump_d;
  logic [AW-1:0] rs_d, rt_d, dest_d;
  logic sf[2], sd[2], fd[2], fx[2];
  logic [1:0] fax[2], fbx[2], fad[2], fbd[2];
`ifdef HAZARD_PERF_EN
  logic [31:0] sc[2], fc[2];
`endif
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mips_hazard_unit #(.REG_AW(AW), .M_STAGES(g + 1)) u_dut (
      .clk(clk), .reset_n(reset_n), .valid_d(valid_d), .rs_d(rs_d), .rt_d(rt_d),
      .use_rs_d(use_rs_d), .use_rt_d(use_rt_d), .dest_d(dest_d), .reg_write_d(reg_write_d),
      .mem_to_reg_d(mem_to_reg_d), .branch_d(branch_d), .pc_src_d(pc_src_d), .jump_d(jump_d),
      .stall_f(sf[g]), .stall_d(sd[g]), .flush_d(fd[g]), .flush_x(fx[g]),
      .fwd_a_x(fax[g]), .fwd_b_x(fbx[g]), .fwd_a_d(fad[g]), .fwd_b_d(fbd[g])
`ifdef HAZARD_PERF_EN
      , .stall_count(sc[g]), .flush_count(fc[g])
`endif
    );
  end
  // Model: pl[c][age], age 0 = X, 1..M = Mk, M+1 = W; wr already folds in valid.
  typedef struct {bit wr; bit ld; bit ur; bit ut; int rs; int rt; int dest;} ins_t;
  ins_t pl[2][6];
  int unsigned cs[2], cf[2];
  int n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  function automatic bit hit(input ins_t p, input int r, input bit u);
    return p.wr && p.dest == r && r != 0 && u;
  endfunction
  function automatic bit m_stall(input int c);
    int m = c + 1;
    bit s = 0, h;
    for (int a = 0; a <= m; a++) begin
      h = hit(pl[c][a], int'(rs_d), use_rs_d) || hit(pl[c][a], int'(rt_d), use_rt_d);
      if (h && pl[c][a].ld && a < m) s = 1;
      if (h && branch_d && (a == 0 || pl[c][a].ld)) s = 1;
    end
    return s && valid_d;
  endfunction
  function automatic int m_fx(input int c, input bit b);
    int m = c + 1;
    int r = b ? pl[c][0].rt : pl[c][0].rs;
    bit u = b ? pl[c][0].ut : pl[c][0].ur;
    for (int k = 1; k <= m; k++) if (hit(pl[c][k], r, u) && !pl[c][k].ld) return k;
    return hit(pl[c][m+1], r, u) ? m + 1 : 0;
  endfunction
  function automatic int m_fd(input int c, input bit b);
    int r = b ? int'(rt_d) : int'(rs_d);
    bit u = b ? use_rt_d : use_rs_d;
    if (!branch_d) return 0;
    for (int k = 1; k <= c + 1; k++) if (hit(pl[c][k], r, u) && !pl[c][k].ld) return k;
    return 0;
  endfunction
  function automatic bit m_flush(input int c);
    return valid_d && (pc_src_d || jump_d) && !m_stall(c);
  endfunction
  task automatic compare();
    for (int c = 0; c < 2; c++) begin
      check($sformatf("m%0d stall_f", c + 1), sf[c], m_stall(c));
      check($sformatf("m%0d stall_d", c + 1), sd[c], m_stall(c));
      check($sformatf("m%0d flush_x", c + 1), fx[c], m_stall(c));
      check($sformatf("m%0d flush_d", c + 1), fd[c], m_flush(c));
      check($sformatf("m%0d fwd_a_x", c + 1), fax[c], m_fx(c, 0));
      check($sformatf("m%0d fwd_b_x", c + 1), fbx[c], m_fx(c, 1));
      check($sformatf("m%0d fwd_a_d", c + 1), fad[c], m_fd(c, 0));
      check($sformatf("m%0d fwd_b_d", c + 1), fbd[c], m_fd(c, 1));
`ifdef HAZARD_PERF_EN
      check($sformatf("m%0d stall_count", c + 1), sc[c], cs[c]);
      check($sformatf("m%0d flush_count", c + 1), fc[c], cf[c]);
`endif
    end
  endtask
  task automatic advance();
    bit s, f;
    for (int c = 0; c < 2; c++) begin
      s = m_stall(c);
      f = m_flush(c);
      cs[c] += s;
      cf[c] += f;
      for (int a = c + 2; a >= 1; a--) pl[c][a] = pl[c][a-1];
      if (valid_d && !s)
        pl[c][0] = '{wr: reg_write_d, ld: mem_to_reg_d, ur: use_rs_d, ut: use_rt_d,
                     rs: int'(rs_d), rt: int'(rt_d), dest: int'(dest_d)};
      else pl[c][0] = '{default: 0};
    end
  endtask
  task automatic clear_model();
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < 6; a++) pl[c][a] = '{default: 0};
      cs[c] = 0;
      cf[c] = 0;
    end
  endtask
  task automatic drive(input bit v, input int rs, input int rt, input bit ur, input bit ut,
                       input int dst, input bit rw, input bit ld, input bit br, input bit pc, input bit jp);
    valid_d = v; rs_d = AW'(rs); rt_d = AW'(rt); use_rs_d = ur; use_rt_d = ut;
    dest_d = AW'(dst); reg_write_d = rw; mem_to_reg_d = ld; branch_d = br; pc_src_d = pc; jump_d = jp;
  endtask
  task automatic step(input bit v, input int rs, input int rt, input bit ur, input bit ut,
                      input int dst, input bit rw, input bit ld, input bit br, input bit pc, input bit jp);
    @(negedge clk);
    drive(v, rs, rt, ur, ut, dst, rw, ld, br, pc, jp);
    #1 compare();
    advance();
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic alu(input int dst, input int rs, input int rt);
    step(1, rs, rt, 1, 1, dst, 1, 0, 0, 0, 0);
  endtask
  task automatic lw(input int dst);
    step(1, 0, dst, 1, 0, dst, 1, 1, 0, 0, 0);
  endtask
  task automatic beq(input int rs, input int rt, input bit pc);
    step(1, rs, rt, 1, 1, 0, 0, 0, 1, pc, 0);
  endtask
  task automatic check_zero(input string tag);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("%s m%0d stall", tag, c + 1), sf[c] | sd[c] | fx[c], 0);
      check($sformatf("%s m%0d flush_d", tag, c + 1), fd[c], 0);
      check($sformatf("%s m%0d fwd", tag, c + 1), {fax[c], fbx[c], fad[c], fbd[c]}, 0);
    end
  endtask
  initial begin
    clear_model();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    #1 compare();
    advance();
    // load-use: one stall for M=1, two for M=2, then forward from W
    lw(2);
    alu(3, 2, 4);
    check("lu m1 stall c1", sf[0], 1);
    check("lu m2 stall c1", sf[1], 1);
    alu(3, 2, 4);
    check("lu m1 stall c2", sf[0], 0);
    check("lu m2 stall c2", sf[1], 1);
    alu(3, 2, 4);
    check("lu m1 fwd_a_x", fax[0], 2);
    check("lu m2 stall c3", sf[1], 0);
    idle(1);
    check("lu m2 fwd_a_x", fax[1], 3);
    idle(4);
    // same dest in two older stages: youngest wins
    alu(5, 0, 0);
    alu(5, 0, 0);
    alu(6, 0, 5);
    idle(1);
    check("young m1 fwd_b_x", fbx[0], 1);
    check("young m2 fwd_b_x", fbx[1], 1);
    idle(4);
    // register zero never forwards or stalls
    alu(0, 1, 1);
    alu(7, 0, 0);
    check("zero m1 stall", sf[0], 0);
    check("zero m2 stall", sf[1], 0);
    idle(1);
    check("zero m1 fwd_a_x", fax[0], 0);
    check("zero m2 fwd_a_x", fax[1], 0);
    idle(4);
    // branch after ALU producer: stall, flush suppressed, then ID forward
    alu(4, 1, 1);
    beq(4, 6, 1);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("br m%0d stall", c + 1), sf[c], 1);
      check($sformatf("br m%0d flush hold", c + 1), fd[c], 0);
    end
    beq(4, 6, 1);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("br m%0d stall clr", c + 1), sf[c], 0);
      check($sformatf("br m%0d fwd_a_d", c + 1), fad[c], 1);
      check($sformatf("br m%0d fwd_b_d", c + 1), fbd[c], 0);
      check($sformatf("br m%0d flush", c + 1), fd[c], 1);
    end
    idle(4);
    // jump with no use bits never stalls
    lw(3);
    step(1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 1);
    check("jmp m1 stall", sf[0], 0);
    check("jmp m1 flush", fd[0], 1);
    // async reset with a load in X
    lw(2);
    @(negedge clk);
    drive(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0);
    reset_n = 1'b0;
    #1 check_zero("midrst");
    clear_model();
    @(negedge clk);
    reset_n = 1'b1;
    #1 compare();
    check("post rst m1 stall", sf[0], 0);
    check("post rst m2 stall", sf[1], 0);
    advance();
    // randomized traffic over a small register set to provoke many matches
    repeat (600) begin
      step(bit'($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $urandom_range(0, 3),
           bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) == 0),
           bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 5) == 0));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
